acc_ctrl: RTL and testbench

- Sequencer for the accumulator bank that sits between the systolic array (SA) and the GLB.
- Takes one row-valid strobe from SA column 0 and produces per-column, skewed psum write enables across K-tile passes.
- After the last pass it drains the per-column FIFOs by injecting zero-psum rows, flagging valid ofmap output per column, then pulses done.
- Because the drain writes zeros back, the FIFOs are left full of zeros, so the next job accumulates onto zero.

---
 rtl/acc_pkg.sv | 28 ++
 rtl/acc_skew_pipe.sv | 26 ++
 rtl/acc_ctrl.sv | 139 +++++++++++++
 tb/tb_acc_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator-bank sequencer.
package acc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    // One skew-pipe token: write this column's FIFO, optionally with a zero psum.
    typedef struct packed {
        logic en;
        logic zero;
    } token_t;

    // Ceiling log2, never below 1 so a depth-1 FIFO still gets a 1-bit counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/acc_skew_pipe.sv
// Token skew pipe: stage j carries the token injected j+1 cycles ago, so each
// SA column sees its write enable one cycle after its left neighbour.
module acc_skew_pipe
    import acc_pkg::*;
#(
    parameter int PE_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  token_t                inject,
    output token_t [PE_SIZE-1:0]  stage
);

    // Shift tokens one column to the right each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= inject;
            for (int j = 1; j < PE_SIZE; j++) begin
                stage[j] <= stage[j-1];
            end
        end
    end

endmodule

// File: rtl/acc_ctrl.sv
// Accumulator-bank sequencer: counts rows/passes of SA output, then drains the
// per-column FIFOs with zero rows (leaving them zeroed for the next job).
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int PE_SIZE    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int KTILE_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [KTILE_W-1:0] ktile_num_i,
    input  logic               sa_valid_i,
    output logic [PE_SIZE-1:0] psum_en_o,
    output logic [PE_SIZE-1:0] psum_zero_o,
    output logic [PE_SIZE-1:0] ofmap_valid_o,
    output logic               last_pass_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ovf_err_o
);

    localparam int              ROW_W    = clog2(FIFO_DEPTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FIFO_DEPTH - 1);

    state_t               state, state_nxt;
    logic [ROW_W-1:0]     row_cnt;
    logic [KTILE_W-1:0]   pass_cnt, pass_max;
    token_t               inject;
    token_t [PE_SIZE-1:0] stage;
    logic                 row_last, final_pass, accept, inflight;

    assign accept     = (state == S_IDLE) && start_i;
    assign row_last   = (row_cnt == ROW_LAST);
    assign final_pass = (pass_cnt == pass_max);

    acc_skew_pipe #(.PE_SIZE(PE_SIZE)) u_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .inject (inject),
        .stage  (stage)
    );

    // Tokens still short of the last column; once only the last stage can hold
    // one, the job finishes next cycle together with that final write.
    always_comb begin
        inflight = 1'b0;
        for (int j = 0; j < PE_SIZE - 1; j++) begin
            inflight = inflight | stage[j].en;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_ACC;
            S_ACC:   if (sa_valid_i && row_last && final_pass) state_nxt = S_DRAIN;
            S_DRAIN: if (row_last) state_nxt = S_FLUSH;
            S_FLUSH: if (!inflight) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs, including the token injected into column 0 this cycle.
    always_comb begin
        inject      = '0;
        busy_o      = (state != S_IDLE);
        done_o      = 1'b0;
        last_pass_o = 1'b0;
        case (state)
            S_ACC: begin
                last_pass_o = final_pass;
                inject.en   = sa_valid_i;
            end
            S_DRAIN: begin
                inject.en   = 1'b1;
                inject.zero = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Row / pass counters; the drain reuses row_cnt to emit exactly FIFO_DEPTH rows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt  <= '0;
            pass_cnt <= '0;
            pass_max <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    pass_max <= (ktile_num_i == '0) ? '0 : ktile_num_i - KTILE_W'(1);
                    pass_cnt <= '0;
                    row_cnt  <= '0;
                end
                S_ACC: if (sa_valid_i) begin
                    if (row_last) begin
                        row_cnt  <= '0;
                        pass_cnt <= pass_cnt + KTILE_W'(1);
                    end else begin
                        row_cnt  <= row_cnt + ROW_W'(1);
                    end
                end
                S_DRAIN: row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
                default: ;
            endcase
        end
    end

    // Sticky flag for SA rows arriving when no pass is open; a new job clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)                              ovf_err_o <= 1'b0;
        else if (accept)                         ovf_err_o <= 1'b0;
        else if (sa_valid_i && state != S_ACC)   ovf_err_o <= 1'b1;
    end

    // Per-column accumulator controls straight from the skew stages.
    always_comb begin
        psum_en_o     = '0;
        psum_zero_o   = '0;
        ofmap_valid_o = '0;
        for (int j = 0; j < PE_SIZE; j++) begin
            psum_en_o[j]     = stage[j].en;
            psum_zero_o[j]   = stage[j].en & stage[j].zero;
            ofmap_valid_o[j] = stage[j].en & stage[j].zero;
        end
    end

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl: cycle traces of each job checked against
// hand-derived timing windows.
module tb_acc_ctrl;

    localparam int PE = 4;
    localparam int FD = 4;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [KW-1:0] ktile_num_i = '0;
    logic          sa_valid_i = 1'b0;
    logic [PE-1:0] psum_en_o, psum_zero_o, ofmap_valid_o;
    logic          last_pass_o, busy_o, done_o, ovf_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PE-1:0] en_tr [64];
    logic [PE-1:0] zero_tr [64];
    logic [PE-1:0] ofm_tr [64];
    logic          done_tr [64];
    logic          last_tr [64];
    logic          busy_tr [64];
    logic          ovf_tr [64];

    always #5 clk = ~clk;

    acc_ctrl #(.PE_SIZE(PE), .FIFO_DEPTH(FD), .KTILE_W(KW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .ktile_num_i   (ktile_num_i),
        .sa_valid_i    (sa_valid_i),
        .psum_en_o     (psum_en_o),
        .psum_zero_o   (psum_zero_o),
        .ofmap_valid_o (ofmap_valid_o),
        .last_pass_o   (last_pass_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .ovf_err_o     (ovf_err_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Start a job in cycle -1, then record outputs of cycles 0..ncyc-1 while
    // driving sa_valid_i / start_i from the given per-cycle masks.
    task automatic run_trace(input logic [KW-1:0] k, input logic [63:0] pat,
                             input logic [63:0] smask, input int ncyc);
        cyc();
        start_i     = 1'b1;
        ktile_num_i = k;
        sa_valid_i  = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            cyc();
            en_tr[t]   = psum_en_o;
            zero_tr[t] = psum_zero_o;
            ofm_tr[t]  = ofmap_valid_o;
            done_tr[t] = done_o;
            last_tr[t] = last_pass_o;
            busy_tr[t] = busy_o;
            ovf_tr[t]  = ovf_err_o;
            sa_valid_i = pat[t];
            start_i    = smask[t];
        end
        start_i    = 1'b0;
        sa_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [3*PE+3:0] outs;
        rst_n = 1'b0;
        cyc();
        cyc();
        outs = {psum_en_o, psum_zero_o, ofmap_valid_o, last_pass_o, busy_o, done_o, ovf_err_o};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h exp 0", outs);
        end
        rst_n = 1'b1;
        cyc();
        // Abort a 3-pass job during pass 1 (6 rows in).
        start_i     = 1'b1;
        ktile_num_i = 8'd3;
        cyc();
        start_i    = 1'b0;
        sa_valid_i = 1'b1;
        repeat (6) cyc();
        n_cmp++;
        if ({busy_o, last_pass_o, psum_en_o} !== {1'b1, 1'b0, 4'b1111}) begin
            n_bad++;
            $display("FAIL midjob_state got %b exp 1_0_1111", {busy_o, last_pass_o, psum_en_o});
        end
        rst_n      = 1'b0;
        sa_valid_i = 1'b0;
        cyc();
        outs = {psum_en_o, psum_zero_o, ofmap_valid_o, last_pass_o, busy_o, done_o, ovf_err_o};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL midjob_reset got %h exp 0", outs);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            cyc();
            n_cmp++;
            if ({done_o, busy_o, psum_en_o} !== '0) begin
                n_bad++;
                $display("FAIL post_reset_idle t=%0d got %b exp 0", t, {done_o, busy_o, psum_en_o});
            end
        end
    endtask

    // One-pass job with 4 back-to-back rows in cycles 0..3.
    task automatic test_single_pass(input logic [KW-1:0] k);
        logic [PE-1:0] exp_en, exp_zero;
        run_trace(k, 64'hF, 64'h0, 16);
        for (int t = 0; t < 16; t++) begin
            for (int j = 0; j < PE; j++) begin
                exp_en[j]   = (t >= 1 + j) && (t <= 8 + j);
                exp_zero[j] = (t >= 5 + j) && (t <= 8 + j);
            end
            n_cmp++;
            if (en_tr[t] !== exp_en) begin
                n_bad++;
                $display("FAIL single_en k=%0d t=%0d got %b exp %b", k, t, en_tr[t], exp_en);
            end
            n_cmp++;
            if (zero_tr[t] !== exp_zero) begin
                n_bad++;
                $display("FAIL single_zero k=%0d t=%0d got %b exp %b", k, t, zero_tr[t], exp_zero);
            end
            n_cmp++;
            if (ofm_tr[t] !== exp_zero) begin
                n_bad++;
                $display("FAIL single_ofmap k=%0d t=%0d got %b exp %b", k, t, ofm_tr[t], exp_zero);
            end
            n_cmp++;
            if ({done_tr[t], last_tr[t], busy_tr[t]} !== {t == 12, t <= 3, t <= 12}) begin
                n_bad++;
                $display("FAIL single_ctl k=%0d t=%0d got %b exp %b", k, t,
                         {done_tr[t], last_tr[t], busy_tr[t]}, {t == 12, t <= 3, t <= 12});
            end
        end
    endtask

    // Three passes with gaps: rows at cycles 0,1,3,4,7,8,9,11,12,14,16,17.
    task automatic test_ktile3_gaps();
        logic [63:0] pat;
        int real_cnt [PE];
        int zero_cnt [PE];
        int order_bad [PE];
        int nv, last_v;
        pat    = 64'h35B9B;
        last_v = 17;
        run_trace(8'd3, pat, 64'h0, 30);
        nv = 0;
        for (int j = 0; j < PE; j++) begin
            real_cnt[j] = 0;
            zero_cnt[j] = 0;
            order_bad[j] = 0;
        end
        for (int t = 0; t < 30; t++) begin
            n_cmp++;
            if (last_tr[t] !== (nv >= 8 && nv < 12)) begin
                n_bad++;
                $display("FAIL k3_last t=%0d got %b exp %b", t, last_tr[t], (nv >= 8 && nv < 12));
            end
            n_cmp++;
            if ({done_tr[t], busy_tr[t]} !== {t == last_v + 9, t <= last_v + 9}) begin
                n_bad++;
                $display("FAIL k3_done_busy t=%0d got %b exp %b", t, {done_tr[t], busy_tr[t]},
                         {t == last_v + 9, t <= last_v + 9});
            end
            if (t >= 1 && t <= last_v + 1) begin
                n_cmp++;
                if (en_tr[t][0] !== pat[t-1]) begin
                    n_bad++;
                    $display("FAIL k3_col0_timing t=%0d got %b exp %b", t, en_tr[t][0], pat[t-1]);
                end
            end
            for (int j = 0; j < PE; j++) begin
                if (en_tr[t][j] && !zero_tr[t][j]) begin
                    real_cnt[j]++;
                    if (zero_cnt[j] != 0) order_bad[j]++;
                end
                if (en_tr[t][j] && zero_tr[t][j]) zero_cnt[j]++;
            end
            if (pat[t]) nv++;
        end
        for (int j = 0; j < PE; j++) begin
            n_cmp++;
            if (real_cnt[j] != 12 || zero_cnt[j] != 4 || order_bad[j] != 0) begin
                n_bad++;
                $display("FAIL k3_tokens col=%0d got real=%0d zero=%0d misorder=%0d exp 12/4/0",
                         j, real_cnt[j], zero_cnt[j], order_bad[j]);
            end
        end
    endtask

    // Stray rows in IDLE and in DRAIN: no tokens, sticky error, cleared by start.
    task automatic test_stray();
        logic [PE-1:0] exp_en;
        sa_valid_i = 1'b1;
        cyc();
        cyc();
        sa_valid_i = 1'b0;
        n_cmp++;
        if ({ovf_err_o, busy_o, psum_en_o} !== {1'b1, 1'b0, 4'b0000}) begin
            n_bad++;
            $display("FAIL stray_idle got %b exp 1_0_0000", {ovf_err_o, busy_o, psum_en_o});
        end
        cyc();
        n_cmp++;
        if ({ovf_err_o, psum_en_o} !== {1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL stray_idle_hold got %b exp 1_0000", {ovf_err_o, psum_en_o});
        end
        run_trace(8'd1, 64'h2F, 64'h0, 16);
        for (int t = 0; t < 16; t++) begin
            for (int j = 0; j < PE; j++) exp_en[j] = (t >= 1 + j) && (t <= 8 + j);
            n_cmp++;
            if (ovf_tr[t] !== (t >= 6)) begin
                n_bad++;
                $display("FAIL stray_drain_ovf t=%0d got %b exp %b", t, ovf_tr[t], (t >= 6));
            end
            n_cmp++;
            if (en_tr[t] !== exp_en) begin
                n_bad++;
                $display("FAIL stray_drain_en t=%0d got %b exp %b", t, en_tr[t], exp_en);
            end
        end
        run_trace(8'd1, 64'hF, 64'h0, 16);
        for (int t = 0; t < 16; t++) begin
            n_cmp++;
            if ({ovf_tr[t], done_tr[t]} !== {1'b0, t == 12}) begin
                n_bad++;
                $display("FAIL stray_cleared t=%0d got %b exp %b", t, {ovf_tr[t], done_tr[t]}, {1'b0, t == 12});
            end
        end
    endtask

    // Two-pass job with start pulses in ACC, DRAIN and DONE that must be ignored.
    task automatic test_start_busy();
        logic [PE-1:0] exp_en, exp_zero;
        run_trace(8'd2, 64'hFF, 64'h10404, 20);
        for (int t = 0; t < 20; t++) begin
            for (int j = 0; j < PE; j++) begin
                exp_en[j]   = (t >= 1 + j) && (t <= 12 + j);
                exp_zero[j] = (t >= 9 + j) && (t <= 12 + j);
            end
            n_cmp++;
            if ({en_tr[t], zero_tr[t]} !== {exp_en, exp_zero}) begin
                n_bad++;
                $display("FAIL busy_start_tokens t=%0d got %b exp %b", t, {en_tr[t], zero_tr[t]}, {exp_en, exp_zero});
            end
            n_cmp++;
            if ({done_tr[t], last_tr[t], busy_tr[t]} !== {t == 16, t >= 4 && t <= 7, t <= 16}) begin
                n_bad++;
                $display("FAIL busy_start_ctl t=%0d got %b exp %b", t, {done_tr[t], last_tr[t], busy_tr[t]},
                         {t == 16, t >= 4 && t <= 7, t <= 16});
            end
        end
    endtask

    // Second one-pass job started in the cycle right after the first done.
    task automatic test_back_to_back();
        logic [PE-1:0] exp_en;
        logic          exp_busy, exp_last;
        run_trace(8'd1, 64'h3C00F, 64'h2000, 30);
        for (int t = 0; t < 30; t++) begin
            for (int j = 0; j < PE; j++)
                exp_en[j] = ((t >= 1 + j) && (t <= 8 + j)) || ((t >= 15 + j) && (t <= 22 + j));
            exp_busy = (t <= 12) || (t >= 14 && t <= 26);
            exp_last = (t <= 3) || (t >= 14 && t <= 17);
            n_cmp++;
            if (en_tr[t] !== exp_en) begin
                n_bad++;
                $display("FAIL b2b_en t=%0d got %b exp %b", t, en_tr[t], exp_en);
            end
            n_cmp++;
            if ({done_tr[t], busy_tr[t], last_tr[t]} !== {t == 12 || t == 26, exp_busy, exp_last}) begin
                n_bad++;
                $display("FAIL b2b_ctl t=%0d got %b exp %b", t, {done_tr[t], busy_tr[t], last_tr[t]},
                         {t == 12 || t == 26, exp_busy, exp_last});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass(8'd1);
        test_ktile3_gaps();
        test_single_pass(8'd0);
        test_stray();
        test_start_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
